fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//   Parametrised fetch stage with an in-order prefetch queue, replacing the single PC register and fetch/decode flop.
//   Issues PCs to a variable-latency instruction memory through a valid/ready request port and buffers up to DEPTH
//   in-flight or returned instructions. Feeds the decode stage register {instr, pc, pc+4} and honours decode stall and
//   execute-stage redirect (taken branch/jump), discarding stale responses after a redirect.
// PARAMETERS
//   XLEN   32  PC/address width
//   DEPTH  4   prefetch queue slots; power of 2, >=2; sustained 1 instr/cycle requires DEPTH >= imem latency + 2
// PORTS
//   clk             in   1     clock; all state on rising edge
//   reset           in   1     asynchronous, active-high reset
//   start_pc        in   XLEN  PC loaded on reset; stable while reset is high
//   imem_req_valid  out  1     request valid
//   imem_req_ready  in   1     memory accepts request
//   imem_req_addr   out  XLEN  request address (fetch_pc)
//   imem_rsp_valid  in   1     response valid; in request order, no backpressure
//   imem_rsp_data   in   32    instruction word
//   redirect_valid  in   1     taken branch/jump in execute (PCSrcE)
//   redirect_pc     in   XLEN  redirect target (PCTargetE)
//   stall_d         in   1     decode is not consuming this cycle (StallD)
//   valid_d         out  1     decode register holds a live instruction
//   instr_d         out  32    decode instruction; 0 when valid_d=0
//   pc_d            out  XLEN  decode PC
//   pcplus4_d       out  XLEN  pc_d + 4
// BEHAVIOUR
//   Reset (async): fetch_pc=start_pc; queue empty; drop_cnt=0; valid_d=0; instr_d/pc_d/pcplus4_d=0; imem_req_valid=0.
//   Queue: ring of DEPTH slots {pc, instr, filled}; three pointers, all mod DEPTH:
//     alloc_ptr (advances on request handshake)
//     fill_ptr  (advances on accepted response)
//     head_ptr  (advances on dequeue)
//   occ = allocated slots not yet dequeued; can_issue = (occ + drop_cnt < DEPTH).
//   imem_req_valid = can_issue & !redirect_valid (combinational); imem_req_addr = fetch_pc.
//   Request handshake: slot[alloc_ptr] <= {fetch_pc, filled=0}; fetch_pc += 4 (wraps mod 2^XLEN).
//   Response: if drop_cnt>0, discard and decrement drop_cnt. Otherwise write instr into slot[fill_ptr] and set filled.
//   Response with nothing outstanding is a protocol error; ignore it and fire a sim assertion.
//   Dequeue when slot[head_ptr].filled & (!valid_d | !stall_d): decode reg <= {instr, pc, pc+4}, valid_d=1.
//   If valid_d & !stall_d & no filled head: valid_d=0, instr_d=0 (bubble).
//   If stall_d & valid_d: decode reg holds.
//   Latency: request handshake at t with response at t+1 gives valid_d high from t+3 (filled slot dequeued in t+2).
//   Redirect (priority over all): decode reg cleared (valid_d=0, instr_d=0) even if stall_d; queue emptied;
//     drop_cnt <= drop_cnt + (allocated-unfilled slots) - (1 if a response is counted for drop this cycle);
//     fetch_pc <= redirect_pc; no request issued in the redirect cycle.
//     A response arriving in the redirect cycle belongs to the old stream and is discarded.
//   drop_cnt width clog2(DEPTH)+1; never exceeds DEPTH by construction of can_issue.
//   Queue full (occ=DEPTH): no requests; the queue never overflows because responses always have a slot.
//   Reset mid-stream: all state cleared immediately; after release, fetch restarts at start_pc.
//     Responses to pre-reset requests must not be delivered (memory is reset by the same signal).
// TESTING
//   1 reset start_pc=0x1000, ready=1, 1-cycle latency -> addrs 0x1000,0x1004,..;
//     valid_d first at cycle 3, pc_d=0x1000, pcplus4_d=0x1004; then one instr/cycle.
//   2 stall_d high 5 cycles, DEPTH=4 -> decode outputs frozen, req_valid drops at occ=4;
//     release -> pc_d continues +4, no gap or duplicate.
//   3 redirect_pc=0x2000 with 2 outstanding, latency 3 -> valid_d=0 next cycle, 2 responses dropped,
//     next valid pc_d=0x2000.
//   4 redirect + stall_d + rsp_valid same cycle -> valid_d=0, instr_d=0, that rsp discarded, drop_cnt correct.
//   5 random imem_req_ready 50%, latency 1..3 -> valid pc_d strictly +4, instr_d matches memory model at pc_d.
//   6 reset pulse mid-stream -> outputs 0 without clock edge; after release first req addr = start_pc.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage with an in-order prefetch queue feeding the decode register.
// Stale responses after a redirect are counted and discarded.
module fetch_prefetch_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] start_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  output logic            valid_d,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  slot_pc    [DEPTH];
  logic [31:0]      slot_instr [DEPTH];
  logic [DEPTH-1:0] slot_filled;

  logic [CW-1:0] alloc_ptr;
  logic [CW-1:0] fill_ptr;
  logic [CW-1:0] head_ptr;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] occ;
  logic [CW-1:0] pend;
  logic [CW:0]   budget;
  logic [CW:0]   redir_drop;
  logic [PW-1:0] a_idx;
  logic [PW-1:0] f_idx;
  logic [PW-1:0] h_idx;

  logic can_issue;
  logic req_fire;
  logic rsp_drop;
  logic rsp_fill;
  logic rsp_old;
  logic head_ready;
  logic deq;

  assign a_idx = alloc_ptr[PW-1:0];
  assign f_idx = fill_ptr[PW-1:0];
  assign h_idx = head_ptr[PW-1:0];

  // Pointers carry one extra wrap bit so full and empty differ.
  assign occ    = alloc_ptr - head_ptr;
  assign pend   = alloc_ptr - fill_ptr;
  assign budget = {1'b0, occ} + {1'b0, drop_cnt};

  assign can_issue = budget < DEPTH_C;

  assign imem_req_valid = can_issue & ~redirect_valid & ~reset;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_drop = imem_rsp_valid & (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid & ~redirect_valid
                  & (drop_cnt == '0) & (pend != '0);

  // A response in the redirect cycle is the oldest old-stream one.
  assign rsp_old    = imem_rsp_valid & ((drop_cnt != '0) | (pend != '0));
  assign redir_drop = {1'b0, drop_cnt} + {1'b0, pend}
                    - {{CW{1'b0}}, rsp_old};

  assign head_ready = slot_filled[h_idx] & (occ != '0);
  assign deq = ~redirect_valid & head_ready & (~valid_d | ~stall_d);

  // Queue control: pointers, fill flags, fetch PC and drop count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= start_pc;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      drop_cnt    <= '0;
      slot_filled <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      drop_cnt    <= redir_drop[CW-1:0];
      slot_filled <= '0;
    end else begin
      if (req_fire) begin
        slot_filled[a_idx] <= 1'b0;
        alloc_ptr          <= alloc_ptr + CW'(1);
        fetch_pc           <= fetch_pc + XLEN'(4);
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (rsp_fill) begin
        slot_filled[f_idx] <= 1'b1;
        fill_ptr           <= fill_ptr + CW'(1);
      end
      if (deq) begin
        head_ptr <= head_ptr + CW'(1);
      end
    end
  end

  // Slot payload storage; validity lives in slot_filled.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      slot_pc[a_idx] <= fetch_pc;
    end
    if (rsp_fill) begin
      slot_instr[f_idx] <= imem_rsp_data;
    end
  end

  // Decode register: redirect squashes, else load, bubble or hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_d   <= 1'b0;
      instr_d   <= '0;
      pc_d      <= '0;
      pcplus4_d <= '0;
    end else if (redirect_valid) begin
      valid_d <= 1'b0;
      instr_d <= '0;
    end else if (deq) begin
      valid_d   <= 1'b1;
      instr_d   <= slot_instr[h_idx];
      pc_d      <= slot_pc[h_idx];
      pcplus4_d <= slot_pc[h_idx] + XLEN'(4);
    end else if (valid_d & ~stall_d) begin
      valid_d <= 1'b0;
      instr_d <= '0;
    end
  end

  // A response with nothing outstanding is a memory protocol error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_rsp_valid && drop_cnt == '0 && pend == '0));
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: random memory/decode/redirect stimulus,
// scoreboard of the expected in-order fetch stream, separate monitor.
module tb_fetch_prefetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] start_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;

  fetch_prefetch_unit #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .start_pc(start_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall_d(stall_d),
    .valid_d(valid_d),
    .instr_d(instr_d),
    .pc_d(pc_d),
    .pcplus4_d(pcplus4_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  pend_t pend_q[$];
  exp_t  exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_due = 0;
  int consumed = 0;

  int ready_pct = 100;
  int lat_lo    = 1;
  int lat_hi    = 1;
  int stall_pct = 0;
  int rdr_pct   = 0;
  bit force_stall = 0;
  bit force_rdr   = 0;
  bit rdr_on_rsp  = 0;
  logic [31:0] force_pc = '0;
  logic [31:0] model_pc = '0;

  int first_hs    = -1;
  int first_valid = -1;
  logic [31:0] first_hs_addr = '0;
  logic [31:0] first_pc      = '0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // One cycle of memory, decode and execute stimulus plus model update.
  task automatic step();
    pend_t p;
    exp_t  e;
    int    lat;
    @(negedge clk);
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
    imem_req_ready = ($urandom_range(99) < ready_pct);
    stall_d = force_stall || ($urandom_range(99) < stall_pct);
    redirect_valid = 1'b0;
    if (force_rdr) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_rdr      = 0;
    end else if (rdr_on_rsp && imem_rsp_valid && valid_d) begin
      redirect_valid = 1'b1;
      stall_d        = 1'b1;
      redirect_pc    = 32'h0000_4000;
      rdr_on_rsp     = 0;
    end else if ($urandom_range(99) < rdr_pct) begin
      redirect_valid = 1'b1;
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
    end
    #1;
    if (redirect_valid) begin
      exp_q.delete();
      model_pc = redirect_pc;
      chk(!imem_req_valid, "no_req_on_redirect",
          32'(imem_req_valid), 32'd0);
    end
    if (imem_req_valid) begin
      chk(imem_req_addr == model_pc, "req_addr", imem_req_addr, model_pc);
    end
    if (imem_req_valid && imem_req_ready) begin
      lat    = $urandom_range(lat_hi, lat_lo);
      p.addr = imem_req_addr;
      p.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = p.due;
      pend_q.push_back(p);
      e.pc    = model_pc;
      e.instr = mem(model_pc);
      exp_q.push_back(e);
      if (first_hs < 0) begin
        first_hs      = cyc;
        first_hs_addr = model_pc;
      end
      model_pc += 32'd4;
    end
  endtask

  task automatic chk_reset_outputs();
    chk(valid_d == 1'b0, "rst_valid_d", 32'(valid_d), 32'd0);
    chk(instr_d == '0, "rst_instr_d", instr_d, 32'd0);
    chk(pc_d == '0, "rst_pc_d", pc_d, 32'd0);
    chk(pcplus4_d == '0, "rst_pcplus4_d", pcplus4_d, 32'd0);
    chk(imem_req_valid == 1'b0, "rst_req_valid",
        32'(imem_req_valid), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever decode consumes an instruction.
  initial begin
    bit          post_rdr;
    bit          prev_hold;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    exp_t        e;
    post_rdr   = 0;
    prev_hold  = 0;
    hold_pc    = '0;
    hold_instr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        post_rdr  = 0;
        prev_hold = 0;
        continue;
      end
      if (post_rdr) begin
        chk(!valid_d && instr_d == '0, "redirect_squash",
            instr_d, 32'd0);
      end
      if (prev_hold) begin
        chk(valid_d && pc_d == hold_pc, "stall_hold_pc", pc_d, hold_pc);
        chk(instr_d == hold_instr, "stall_hold_instr",
            instr_d, hold_instr);
      end
      if (!valid_d) begin
        chk(instr_d == '0, "bubble_instr", instr_d, 32'd0);
      end
      if (valid_d && first_valid < 0) begin
        first_valid = cyc;
        first_pc    = pc_d;
      end
      if (valid_d && !stall_d && !redirect_valid) begin
        consumed++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_instr", pc_d, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk(pc_d == e.pc, "pc_d", pc_d, e.pc);
          chk(instr_d == e.instr, "instr_d", instr_d, e.instr);
          chk(pcplus4_d == e.pc + 32'd4, "pcplus4_d",
              pcplus4_d, e.pc + 32'd4);
        end
      end
      post_rdr   = redirect_valid;
      prev_hold  = valid_d && stall_d && !redirect_valid;
      hold_pc    = pc_d;
      hold_instr = instr_d;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset          = 1'b1;
    start_pc       = 32'h0000_1000;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall_d        = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    model_pc = start_pc;
    reset    = 1'b0;

    // Straight-line fetch, 1-cycle memory.
    ready_pct = 100;
    lat_lo    = 1;
    lat_hi    = 1;
    repeat (12) step();
    chk(first_hs >= 0 && first_valid - first_hs == 3, "first_latency",
        32'(first_valid - first_hs), 32'd3);
    chk(first_pc == 32'h0000_1000, "first_pc", first_pc, 32'h0000_1000);
    c0 = consumed;
    repeat (8) step();
    chk(consumed - c0 == 8, "throughput", 32'(consumed - c0), 32'd8);

    // Decode stall long enough to fill the queue.
    force_stall = 1;
    repeat (5) step();
    chk(!imem_req_valid, "full_no_req", 32'(imem_req_valid), 32'd0);
    force_stall = 0;
    repeat (10) step();

    // Redirect with requests in flight at latency 3.
    lat_lo = 3;
    lat_hi = 3;
    repeat (10) step();
    force_pc  = 32'h0000_2000;
    force_rdr = 1;
    repeat (15) step();

    // Redirect, stall and response in the same cycle.
    lat_lo = 2;
    lat_hi = 2;
    rdr_on_rsp = 1;
    repeat (12) step();
    chk(!rdr_on_rsp, "rdr_rsp_fired", 32'(rdr_on_rsp), 32'd0);
    repeat (10) step();

    // Random traffic.
    ready_pct = 50;
    lat_lo    = 1;
    lat_hi    = 3;
    stall_pct = 30;
    rdr_pct   = 3;
    repeat (1500) step();

    // PC wrap through the top of the address space.
    ready_pct = 100;
    lat_lo    = 1;
    lat_hi    = 1;
    stall_pct = 0;
    rdr_pct   = 0;
    force_pc  = 32'hFFFF_FFF8;
    force_rdr = 1;
    repeat (12) step();
    c0 = consumed;
    repeat (30) step();
    chk(consumed - c0 >= 20, "drain_progress", 32'(consumed - c0), 32'd20);

    // Reset pulse in the middle of random traffic.
    ready_pct = 50;
    lat_lo    = 1;
    lat_hi    = 3;
    stall_pct = 20;
    repeat (20) step();
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_outputs();
    pend_q.delete();
    exp_q.delete();
    last_due       = 0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    stall_d        = 1'b0;
    start_pc       = 32'h0000_3000;
    repeat (2) @(negedge clk);
    model_pc = start_pc;
    first_hs = -1;
    reset    = 1'b0;
    ready_pct = 100;
    lat_lo    = 1;
    lat_hi    = 1;
    stall_pct = 0;
    repeat (20) step();
    chk(first_hs >= 0 && first_hs_addr == 32'h0000_3000, "restart_addr",
        first_hs_addr, 32'h0000_3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
